// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF arbiter and formatter: channel count,
// the "no channel" ID, default widths, the arbiter state encoding and a
// small ID-to-one-hot helper.
package mcdf_pkg;

   localparam int         MCDF_CH_NUM = 3;
   localparam int         MCDF_DW     = 32;
   localparam int         MCDF_PRIO_W = 2;
   localparam logic [1:0] ID_NONE     = 2'b11;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_WAIT_ACK = 2'd1,
      ARB_BUSY     = 2'd2
   } arb_state_e;

   // Decode a channel ID into a one-hot slave vector; ID_NONE gives all zero.
   function automatic logic [MCDF_CH_NUM-1:0] id_to_onehot(input logic [1:0] id);
      logic [MCDF_CH_NUM-1:0] oh;
      oh = '0;
      if (id < 2'(MCDF_CH_NUM)) begin
         oh[id] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// Combinational winner selector for the MCDF arbiter.
// Picks the requesting channel with the lowest priority value. Ties go to
// the first channel in search order: with MCDF_ARB_RR_EN defined the search
// starts at last_id+1 (mod 3), otherwise it always starts at channel 0.
module mcdf_arb_pick
   import mcdf_pkg::*;
#(
   parameter int PRIO_W = MCDF_PRIO_W
) (
   input  logic [MCDF_CH_NUM-1:0]        req,
   input  logic [MCDF_CH_NUM*PRIO_W-1:0] prio,
   input  logic [1:0]                    last_id,
   output logic [1:0]                    win_id,
   output logic                          win_val
);

   logic [PRIO_W-1:0] prio_arr [MCDF_CH_NUM];
   logic [1:0]        start_id;
   logic [1:0]        cand_id;
   logic [PRIO_W-1:0] best_prio;

   generate
      for (genvar gi = 0; gi < MCDF_CH_NUM; gi++) begin : g_prio
         assign prio_arr[gi] = prio[gi*PRIO_W +: PRIO_W];
      end
   endgenerate

`ifdef MCDF_ARB_RR_EN
   assign start_id = (last_id >= 2'(MCDF_CH_NUM-1)) ? 2'd0 : last_id + 2'd1;
`else
   // Fixed search order; the round-robin pointer is not consulted.
   logic unused_last_id;
   assign unused_last_id = ^last_id;
   assign start_id       = 2'd0;
`endif

   // Walk the channels in search order; a strict "<" keeps the earliest tie.
   always_comb begin
      win_id    = ID_NONE;
      win_val   = 1'b0;
      best_prio = '1;
      cand_id   = start_id;
      for (int k = 0; k < MCDF_CH_NUM; k++) begin
         if (req[cand_id] && (!win_val || (prio_arr[cand_id] < best_prio))) begin
            win_id    = cand_id;
            win_val   = 1'b1;
            best_prio = prio_arr[cand_id];
         end
         cand_id = (cand_id == 2'(MCDF_CH_NUM-1)) ? 2'd0 : cand_id + 2'd1;
      end
   end

endmodule

// File: rtl/mcdf_arbiter.sv
// Three-channel MCDF arbiter. Presents a winning channel ID to the formatter,
// releases the slave with a one-cycle a2sx_ack on f2a_ack, then steers that
// slave's data combinationally to the formatter until it goes idle again.
// Optional build macro: MCDF_ARB_RR_EN (round-robin tie break with last_id).
module mcdf_arbiter
   import mcdf_pkg::*;
#(
   parameter int DW     = MCDF_DW,
   parameter int PRIO_W = MCDF_PRIO_W
) (
   input  logic                          clk_i,
   input  logic                          rst_n,
   input  logic [MCDF_CH_NUM-1:0]        slv_req,
   input  logic [MCDF_CH_NUM*PRIO_W-1:0] slv_prio,
   input  logic [MCDF_CH_NUM*DW-1:0]     slv_data,
   input  logic [MCDF_CH_NUM-1:0]        slv_val,
   input  logic                          fmt_id_req,
   input  logic                          f2a_ack,
   output logic [1:0]                    a2f_id,
   output logic                          a2f_id_val,
   output logic [MCDF_CH_NUM-1:0]        a2sx_ack,
   output logic [DW-1:0]                 a2f_data,
   output logic                          a2f_val
);

   arb_state_e             state_reg, state_next;
   logic [1:0]             id_reg, id_next;
   logic [MCDF_CH_NUM-1:0] ack_reg, ack_next;
   logic                   drop_seen_reg, drop_seen_next;
   logic [1:0]             pick_last_id;
   logic [1:0]             win_id;
   logic                   win_val;
   logic [DW-1:0]          data_arr [MCDF_CH_NUM];

   generate
      for (genvar gi = 0; gi < MCDF_CH_NUM; gi++) begin : g_data
         assign data_arr[gi] = slv_data[gi*DW +: DW];
      end
   endgenerate

`ifdef MCDF_ARB_RR_EN
   logic [1:0] last_id_reg;

   // Remember the winner only once its packet is granted; aborts leave it alone.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         last_id_reg <= 2'd2;
      end else if ((state_reg == ARB_WAIT_ACK) && f2a_ack) begin
         last_id_reg <= id_reg;
      end
   end

   assign pick_last_id = last_id_reg;
`else
   assign pick_last_id = 2'd2;
`endif

   mcdf_arb_pick #(
      .PRIO_W (PRIO_W)
   ) u_pick (
      .req     (slv_req),
      .prio    (slv_prio),
      .last_id (pick_last_id),
      .win_id  (win_id),
      .win_val (win_val)
   );

   // State register plus the registered ID, release pulse and drop flag.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ARB_IDLE;
         id_reg        <= ID_NONE;
         ack_reg       <= '0;
         drop_seen_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         id_reg        <= id_next;
         ack_reg       <= ack_next;
         drop_seen_reg <= drop_seen_next;
      end
   end

   // Next-state logic; f2a_ack takes precedence over a falling fmt_id_req.
   always_comb begin
      state_next     = state_reg;
      id_next        = id_reg;
      ack_next       = '0;
      drop_seen_next = 1'b0;
      case (state_reg)
         ARB_IDLE: begin
            if (fmt_id_req && win_val) begin
               state_next = ARB_WAIT_ACK;
               id_next    = win_id;
            end
         end
         ARB_WAIT_ACK: begin
            if (f2a_ack) begin
               state_next = ARB_BUSY;
               ack_next   = id_to_onehot(id_reg);
            end else if (!fmt_id_req) begin
               state_next = ARB_IDLE;
               id_next    = ID_NONE;
            end
         end
         ARB_BUSY: begin
            if (drop_seen_reg && fmt_id_req && !f2a_ack) begin
               state_next = ARB_IDLE;
               id_next    = ID_NONE;
            end else begin
               drop_seen_next = drop_seen_reg | ~fmt_id_req;
            end
         end
         default: begin
            state_next = ARB_IDLE;
            id_next    = ID_NONE;
         end
      endcase
   end

   // Outputs: registered ID/handshake, zero-latency data mux while BUSY.
   always_comb begin
      a2f_id     = id_reg;
      a2f_id_val = (state_reg == ARB_WAIT_ACK);
      a2sx_ack   = ack_reg;
      a2f_data   = '0;
      a2f_val    = 1'b0;
      if ((state_reg == ARB_BUSY) && (id_reg < 2'(MCDF_CH_NUM))) begin
         a2f_data = data_arr[id_reg];
         a2f_val  = slv_val[id_reg];
      end
   end

endmodule

// File: doc/mcdf_arbiter.md
# mcdf_arbiter

Three-channel arbiter sitting directly upstream of the MCDF formatter. While the formatter advertises idle via `fmt_id_req`, it selects one ready slave channel by programmable priority and presents the channel ID on `a2f_id`. On the formatter's `f2a_ack` it releases that slave with a one-cycle `a2sx_ack`, then steers the slave's data stream to the formatter until the formatter signals idle again.

## Interface
- `DW`, 32, data width per channel
- `PRIO_W`, 2, priority field width per channel; 0 is highest priority
- `clk_i`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `slv_req`  in  3  per-channel "packet ready" flags; bit n belongs to channel n
- `slv_prio`  in  3*PRIO_W  per-channel priority; channel n uses bits [n*PRIO_W +: PRIO_W]
- `slv_data`  in  3*DW  per-channel data; channel n uses bits [n*DW +: DW]
- `slv_val`  in  3  per-channel data valid
- `fmt_id_req`  in  1  formatter idle and requesting a channel ID
- `f2a_ack`  in  1  formatter accepted the ID; level, held at least 1 cycle
- `a2f_id`  out  2  selected channel ID; 2'b11 means none
- `a2f_id_val`  out  1  `a2f_id` is valid and awaiting `f2a_ack`
- `a2sx_ack`  out  3  one-hot release pulse to the selected slave
- `a2f_data`  out  DW  data muxed from the selected channel
- `a2f_val`  out  1  valid for `a2f_data`

## Operation
- FSM states: IDLE, WAIT_ACK, BUSY.
- **IDLE**
  - Outputs: `a2f_id`=2'b11, `a2f_id_val`=0.
  - When `fmt_id_req`=1 and `|slv_req`, compute the winner: the lowest `slv_prio` value among requesters.
  - Ties are resolved per Configuration.
  - Register the winner into `a2f_id`, set `a2f_id_val`=1, go to WAIT_ACK.
- **WAIT_ACK**
  - `a2f_id` is frozen, even if `slv_req` of the winner drops.
  - If `f2a_ack`=1: set `a2sx_ack`[id]=1 for exactly one cycle, clear `a2f_id_val`, go to BUSY.
  - Else if `fmt_id_req`=0: abort to IDLE. `a2f_id` returns to 2'b11 and no `a2sx_ack` is issued.
  - If `f2a_ack` and `fmt_id_req` fall in the same cycle, `f2a_ack` wins.
- **BUSY**
  - `a2f_data`=`slv_data`[id] and `a2f_val`=`slv_val`[id]. This path is combinational, with zero latency.
  - A sticky flag `drop_seen` sets when `fmt_id_req`=0 is sampled.
  - Exit to IDLE when `drop_seen`=1, `fmt_id_req`=1 and `f2a_ack`=0. `a2f_id` goes to 2'b11 on that transition.
  - A fresh arbitration may then occur on the very next cycle.
- Outside BUSY: `a2f_data`=0, `a2f_val`=0.
- A long `f2a_ack` level never produces a second `a2sx_ack` pulse.
- **Round-robin pointer `last_id`**
  - Updated to the winner on entry to BUSY.
  - Not updated on an abort.

## Timing
- Reset values: `a2f_id`=2'b11, `a2f_id_val`=0, `a2sx_ack`=0, `a2f_data`=0, `a2f_val`=0, state=IDLE, `last_id`=2, `drop_seen`=0.
- Reset asserted mid-packet returns to IDLE immediately and asynchronously.
- Arbitration latency: condition sampled at edge k; `a2f_id`/`a2f_id_val` valid after edge k (registered, 1 cycle).
- Ack latency: `f2a_ack` sampled at edge k; `a2sx_ack` high from edge k to edge k+1 only.
- Data path: combinational with no register stage. `a2f_val` follows `slv_val`[id] in the same cycle.
- Idle-to-rearbitration minimum gap: 1 cycle after the BUSY exit edge.

## Configuration
- `MCDF_ARB_RR_EN` defined: priority ties are resolved round-robin.
  - Search order starts at `last_id`+1 modulo 3.
  - Example: last winner 0 → candidate order 1, 2, 0.
- `MCDF_ARB_RR_EN` undefined: ties go to the lowest channel index.
  - `last_id` is not implemented.

## Structure
- Shared package `mcdf_pkg` holds:
  - channel count constant `MCDF_CH_NUM`=3
  - `ID_NONE`=2'b11
  - the arbiter state enum
  - `DW` / `PRIO_W` defaults shared with the formatter
- One sub-module, `mcdf_arb_pick`: a combinational winner selector. Inputs: `req`, `prio`, `last_id`. Outputs: `win_id`, `win_val`.

## Test plan
- Reset with `slv_req`=3'b111 and `fmt_id_req`=1 held → all outputs at reset values.
  - After release, `a2f_id`=0 one cycle after the first sampled edge (all priorities equal, `last_id`=2).
- `slv_req`=3'b011, `slv_prio`={2'd0,2'd3,2'd1} (ch2..ch0) → `a2f_id`=2'b00.
  - `f2a_ack` held 3 cycles → `a2sx_ack`=3'b001 for exactly 1 cycle.
- BUSY on ch1 → `a2f_data` tracks `slv_data`[ch1].
  - After `fmt_id_req` drops and then rises with `f2a_ack`=0 → `a2f_id`=2'b11, `a2f_val`=0 on the next cycle.
- RR tie with `MCDF_ARB_RR_EN`: all priorities 1, `slv_req`=3'b111, four back-to-back packets → IDs 0, 1, 2, 0.
  - Without the macro → IDs 0, 0, 0, 0.
- `fmt_id_req` drops in WAIT_ACK without `f2a_ack` → IDLE, `a2sx_ack` stays 0, `last_id` unchanged.
- `rst_n` asserted mid-BUSY → `a2f_val`=0 and `a2f_id`=2'b11 immediately, without waiting for a clock edge.
